// File: rtl/anita3_event_header_reader.sv
// Queues completed-event buffer IDs and streams each buffer's header words from
// the shared header RAM over valid/ready. Optional trailing checksum word: HEADER_CHECKSUM_EN.
module anita3_event_header_reader #(
    parameter int HEADER_WORDS     = 22,
    parameter int QUEUE_DEPTH_LOG2 = 2
) (
    input  logic        clk33_i,
    input  logic        rst_n_i,
    input  logic        event_done_i,
    input  logic [1:0]  event_buffer_i,
    output logic [7:0]  ram_addr_o,
    output logic        ram_rd_o,
    input  logic [15:0] ram_dat_i,
    output logic [15:0] hdr_dat_o,
    output logic        hdr_valid_o,
    output logic        hdr_last_o,
    input  logic        hdr_ready_i,
    output logic [1:0]  hdr_buffer_o,
    output logic [3:0]  buffer_release_o,
    output logic [2:0]  pending_o,
    output logic        overflow_o,
    input  logic        overflow_clr_i
);

    localparam int QD = 1 << QUEUE_DEPTH_LOG2;
    localparam int CW = QUEUE_DEPTH_LOG2 + 1;
    localparam logic [5:0]                  LAST_WORD = 6'(HEADER_WORDS - 1);
    localparam logic [CW-1:0]               FULL_CNT  = CW'(QD);
    localparam logic [CW-1:0]               CNT_ONE   = CW'(1);
    localparam logic [QUEUE_DEPTH_LOG2-1:0] PTR_ONE   = QUEUE_DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_PRESENT,
        S_CSUM,
        S_RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cur_buf_q, cur_buf_d;
    logic [5:0]  word_q, word_d;
    logic [7:0]  ram_addr_q, ram_addr_d;
    logic [15:0] hdr_dat_q, hdr_dat_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic        hdr_last_q, hdr_last_d;
`ifdef HEADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
`endif

    logic [1:0]                  q_mem [QD];
    logic [QUEUE_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]               count_q;
    logic                        overflow_q;

    logic q_empty, q_full;
    logic pop, bypass, push, ovf_set;

    assign q_empty = (count_q == '0);
    assign q_full  = (count_q == FULL_CNT);

    // An idle block with an empty queue takes the ID straight from the input so the
    // first RAM read follows event_done_i by one cycle; nothing is queued in that case.
    assign push    = event_done_i && !bypass && (!q_full || pop);
    assign ovf_set = event_done_i && q_full && !pop;

    always_comb begin
        state_d     = state_q;
        cur_buf_d   = cur_buf_q;
        word_d      = word_q;
        ram_addr_d  = ram_addr_q;
        hdr_dat_d   = hdr_dat_q;
        hdr_valid_d = hdr_valid_q;
        hdr_last_d  = hdr_last_q;
        pop         = 1'b0;
        bypass      = 1'b0;
`ifdef HEADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!q_empty) begin
                    pop        = 1'b1;
                    cur_buf_d  = q_mem[rd_ptr_q];
                    word_d     = 6'd0;
                    ram_addr_d = {q_mem[rd_ptr_q], 6'd0};
                    state_d    = S_FETCH;
`ifdef HEADER_CHECKSUM_EN
                    sum_d      = 16'd0;
`endif
                end else if (event_done_i) begin
                    bypass     = 1'b1;
                    cur_buf_d  = event_buffer_i;
                    word_d     = 6'd0;
                    ram_addr_d = {event_buffer_i, 6'd0};
                    state_d    = S_FETCH;
`ifdef HEADER_CHECKSUM_EN
                    sum_d      = 16'd0;
`endif
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                hdr_dat_d   = ram_dat_i;
                hdr_valid_d = 1'b1;
`ifdef HEADER_CHECKSUM_EN
                hdr_last_d  = 1'b0;
                sum_d       = sum_q + ram_dat_i;
`else
                hdr_last_d  = (word_q == LAST_WORD);
`endif
                state_d     = S_PRESENT;
            end
            S_PRESENT: begin
                if (hdr_ready_i) begin
                    hdr_valid_d = 1'b0;
                    if (hdr_last_q) begin
                        state_d = S_RELEASE;
`ifdef HEADER_CHECKSUM_EN
                    end else if (word_q == LAST_WORD) begin
                        state_d = S_CSUM;
`endif
                    end else begin
                        word_d     = word_q + 6'd1;
                        ram_addr_d = {cur_buf_q, word_q + 6'd1};
                        state_d    = S_FETCH;
                    end
                end
            end
`ifdef HEADER_CHECKSUM_EN
            S_CSUM: begin
                hdr_dat_d   = sum_q;
                hdr_valid_d = 1'b1;
                hdr_last_d  = 1'b1;
                state_d     = S_PRESENT;
            end
`endif
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cur_buf_q   <= 2'd0;
            word_q      <= 6'd0;
            ram_addr_q  <= 8'd0;
            hdr_dat_q   <= 16'd0;
            hdr_valid_q <= 1'b0;
            hdr_last_q  <= 1'b0;
`ifdef HEADER_CHECKSUM_EN
            sum_q       <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            cur_buf_q   <= cur_buf_d;
            word_q      <= word_d;
            ram_addr_q  <= ram_addr_d;
            hdr_dat_q   <= hdr_dat_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_last_q  <= hdr_last_d;
`ifdef HEADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Pending-buffer FIFO; overflow set takes priority over a coincident clear.
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < QD; i++) begin
                q_mem[i] <= 2'd0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                q_mem[wr_ptr_q] <= event_buffer_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_q <= count_q - CNT_ONE;
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign ram_addr_o       = ram_addr_q;
    assign ram_rd_o         = (state_q == S_FETCH);
    assign hdr_dat_o        = hdr_dat_q;
    assign hdr_valid_o      = hdr_valid_q;
    assign hdr_last_o       = hdr_last_q;
    assign hdr_buffer_o     = cur_buf_q;
    assign buffer_release_o = (state_q == S_RELEASE) ? (4'b0001 << cur_buf_q) : 4'b0000;
    assign pending_o        = 3'(count_q);
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_anita3_event_header_reader.sv
// Directed bench for anita3_event_header_reader with a header-RAM model and a word/release scoreboard.
module tb_anita3_event_header_reader;

    localparam int HW = 22;
`ifdef HEADER_CHECKSUM_EN
    localparam int REL_CYC = 69;
`else
    localparam int REL_CYC = 67;
`endif

    logic        clk33_i = 1'b0;
    logic        rst_n_i;
    logic        event_done_i;
    logic [1:0]  event_buffer_i;
    logic [7:0]  ram_addr_o;
    logic        ram_rd_o;
    logic [15:0] ram_dat_i;
    logic [15:0] hdr_dat_o;
    logic        hdr_valid_o;
    logic        hdr_last_o;
    logic        hdr_ready_i;
    logic [1:0]  hdr_buffer_o;
    logic [3:0]  buffer_release_o;
    logic [2:0]  pending_o;
    logic        overflow_o;
    logic        overflow_clr_i;

    int n_checks = 0;
    int n_errors = 0;
    int n_in_hdr = 0;
    logic [18:0] exp_q[$];
    logic [3:0]  exp_rel_q[$];
    logic [15:0] mem [256];

    anita3_event_header_reader dut (
        .clk33_i          (clk33_i),
        .rst_n_i          (rst_n_i),
        .event_done_i     (event_done_i),
        .event_buffer_i   (event_buffer_i),
        .ram_addr_o       (ram_addr_o),
        .ram_rd_o         (ram_rd_o),
        .ram_dat_i        (ram_dat_i),
        .hdr_dat_o        (hdr_dat_o),
        .hdr_valid_o      (hdr_valid_o),
        .hdr_last_o       (hdr_last_o),
        .hdr_ready_i      (hdr_ready_i),
        .hdr_buffer_o     (hdr_buffer_o),
        .buffer_release_o (buffer_release_o),
        .pending_o        (pending_o),
        .overflow_o       (overflow_o),
        .overflow_clr_i   (overflow_clr_i)
    );

    // clock / RAM model
    always #15 clk33_i = ~clk33_i;

    always @(posedge clk33_i) begin
        if (ram_rd_o) ram_dat_i <= mem[ram_addr_o];
    end

    initial begin
        #(30 * 60000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard
    task automatic expect_header(input logic [1:0] b);
        logic [15:0] sum;
        logic [15:0] w;
        logic        last;
        sum = 16'd0;
        for (int n = 0; n < HW; n++) begin
            w    = mem[{b, 6'(n)}];
            sum  = sum + w;
`ifdef HEADER_CHECKSUM_EN
            last = 1'b0;
`else
            last = (n == HW - 1);
`endif
            exp_q.push_back({last, b, w});
        end
`ifdef HEADER_CHECKSUM_EN
        exp_q.push_back({1'b1, b, sum});
`endif
        exp_rel_q.push_back(4'b0001 << b);
    endtask

    always @(negedge clk33_i) begin
        if (rst_n_i) begin
            if (hdr_valid_o && hdr_ready_i) begin
                if (exp_q.size() == 0) check_eq("hdr_unexpected", 32'(exp_q.size()), 1);
                else check_eq("hdr_word", {hdr_last_o, hdr_buffer_o, hdr_dat_o}, exp_q.pop_front());
                n_in_hdr = hdr_last_o ? 0 : n_in_hdr + 1;
            end
            if (buffer_release_o != 4'b0000) begin
                if (exp_rel_q.size() == 0) check_eq("rel_unexpected", buffer_release_o, 0);
                else check_eq("release", buffer_release_o, exp_rel_q.pop_front());
            end
        end
    end

    // driver tasks (entered and left #1 after a rising edge)
    task automatic step();
        @(posedge clk33_i);
        #1;
    endtask

    task automatic pulse_done(input logic [1:0] b);
        event_buffer_i = b;
        event_done_i   = 1'b1;
        step();
        event_done_i   = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || exp_rel_q.size() != 0) && k < 3000) begin
            step();
            k++;
        end
        check_eq("drain", 32'(exp_q.size() + exp_rel_q.size()), 0);
        step();
    endtask

    task automatic wait_release();
        int k;
        k = 0;
        while (buffer_release_o == 4'b0000 && k < 400) begin
            step();
            k++;
        end
        check_eq("release_seen", 32'(buffer_release_o != 4'b0000), 1);
    endtask

    initial begin
        int cyc;
        int k;
        for (int a = 0; a < 256; a++) begin
            mem[a] = {2'b00, 2'(a >> 6), 6'b0, 6'(a)};
        end
        rst_n_i = 1'b0;
        event_done_i = 1'b0;
        event_buffer_i = 2'd0;
        hdr_ready_i = 1'b1;
        overflow_clr_i = 1'b0;
        repeat (3) step();
        check_eq("rst_valid", hdr_valid_o, 0);
        check_eq("rst_dat", hdr_dat_o, 0);
        check_eq("rst_addr", ram_addr_o, 0);
        check_eq("rst_rd", ram_rd_o, 0);
        check_eq("rst_pending", pending_o, 0);
        check_eq("rst_overflow", overflow_o, 0);
        check_eq("rst_release", buffer_release_o, 0);
        rst_n_i = 1'b1;
        step();

        // single header, buffer 2, ready held high
        expect_header(2'd2);
        pulse_done(2'd2);
        check_eq("first_rd", ram_rd_o, 1);
        check_eq("first_addr", ram_addr_o, 8'h80);
        cyc = 1;
        while (buffer_release_o == 4'b0000 && cyc < 200) begin
            step();
            cyc++;
        end
        check_eq("release_cycle", cyc, REL_CYC);
        step();
        check_eq("release_single", buffer_release_o, 0);
        wait_drain();

        // readout stall on word 7 of buffer 3
        expect_header(2'd3);
        pulse_done(2'd3);
        k = 0;
        while (!(hdr_valid_o && n_in_hdr == 7) && k < 200) begin
            step();
            k++;
        end
        hdr_ready_i = 1'b0;
        check_eq("stall_start", hdr_dat_o, 16'h3007);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stall_valid", hdr_valid_o, 1);
            check_eq("stall_dat", hdr_dat_o, 16'h3007);
            check_eq("stall_no_rd", ram_rd_o, 0);
        end
        hdr_ready_i = 1'b1;
        wait_drain();

        // queue fill, overflow, clear
        expect_header(2'd0);
        pulse_done(2'd0);
        for (int b = 1; b < 4; b++) begin
            expect_header(2'(b));
            pulse_done(2'(b));
        end
        check_eq("pending_3", pending_o, 3);
        expect_header(2'd0);
        pulse_done(2'd0);
        check_eq("pending_4", pending_o, 4);
        check_eq("no_overflow_yet", overflow_o, 0);
        pulse_done(2'd1);
        check_eq("overflow_set", overflow_o, 1);
        check_eq("pending_full", pending_o, 4);
        overflow_clr_i = 1'b1;
        pulse_done(2'd3);
        overflow_clr_i = 1'b0;
        check_eq("overflow_set_wins", overflow_o, 1);
        overflow_clr_i = 1'b1;
        step();
        overflow_clr_i = 1'b0;
        check_eq("overflow_clr", overflow_o, 0);

        // push coinciding with the pop of a full queue
        wait_release();
        step();
        expect_header(2'd2);
        pulse_done(2'd2);
        check_eq("pushpop_overflow", overflow_o, 0);
        check_eq("pushpop_pending", pending_o, 4);
        wait_drain();

        // asynchronous reset in the middle of buffer 1
        expect_header(2'd1);
        pulse_done(2'd1);
        k = 0;
        while (!(hdr_valid_o && n_in_hdr == 10) && k < 200) begin
            step();
            k++;
        end
        check_eq("pre_reset_valid", hdr_valid_o, 1);
        #3;
        rst_n_i = 1'b0;
        #1;
        check_eq("arst_valid", hdr_valid_o, 0);
        check_eq("arst_dat", hdr_dat_o, 0);
        check_eq("arst_last", hdr_last_o, 0);
        check_eq("arst_buffer", hdr_buffer_o, 0);
        check_eq("arst_addr", ram_addr_o, 0);
        check_eq("arst_rd", ram_rd_o, 0);
        check_eq("arst_pending", pending_o, 0);
        check_eq("arst_release", buffer_release_o, 0);
        exp_q.delete();
        exp_rel_q.delete();
        n_in_hdr = 0;
        repeat (2) step();
        rst_n_i = 1'b1;
        repeat (5) step();
        expect_header(2'd2);
        pulse_done(2'd2);
        check_eq("fresh_addr", ram_addr_o, 8'h80);
        wait_drain();

        // buffer 1 all ones: checksum 0x0016 when enabled
        for (int n = 0; n < 64; n++) mem[{2'd1, 6'(n)}] = 16'h0001;
        expect_header(2'd1);
        pulse_done(2'd1);
        wait_drain();

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/anita3_event_header_reader.md
Name: anita3_event_header_reader

Overview:
Read-side counterpart to the event header writer. Queues completed-event notifications (done pulse plus 2-bit buffer ID) and reads each buffer's 22-word header out of the shared 4x64x16 header RAM. Streams the words over a valid/ready interface to the readout path, then pulses a one-hot release for that buffer so hold/trigger logic can re-arm it. Runs entirely in the 33 MHz domain; the RAM read port is synchronous to clk33_i.

Parameters:
HEADER_WORDS, 22, number of header words read per event (addresses 0x00..HEADER_WORDS-1)
QUEUE_DEPTH_LOG2, 2, log2 of pending-buffer queue depth (4 entries)

Ports:
clk33_i  in  1  system clock, 33 MHz
rst_n_i  in  1  reset, asynchronous, active-low
event_done_i  in  1  single-cycle pulse: header for event_buffer_i is complete
event_buffer_i  in  2  buffer ID accompanying event_done_i
ram_addr_o  out  8  header RAM read address {buffer[1:0], word[5:0]}
ram_rd_o  out  1  RAM read enable; data valid on ram_dat_i one cycle later
ram_dat_i  in  16  header RAM read data
hdr_dat_o  out  16  header word to readout
hdr_valid_o  out  1  hdr_dat_o valid
hdr_last_o  out  1  final word of the current header, qualified by hdr_valid_o
hdr_ready_i  in  1  readout accepts word when hdr_valid_o && hdr_ready_i
hdr_buffer_o  out  2  buffer ID of the header being streamed
buffer_release_o  out  4  one-hot single-cycle release of the finished buffer
pending_o  out  3  queued buffers not yet started
overflow_o  out  1  sticky: event_done_i arrived while queue full
overflow_clr_i  in  1  clears overflow_o

Behaviour:
- Reset (rst_n_i low, asynchronous) clears all outputs, the queue, word counter and FSM (to IDLE); ram_addr_o=0, hdr_dat_o=0, pending_o=0, overflow_o=0. Reset mid-stream abandons the header; no release is issued.
- Queue: FIFO of 2-bit IDs, depth 2^QUEUE_DEPTH_LOG2.
  - Push on event_done_i. Pop at IDLE->FETCH.
  - Simultaneous push and pop is legal; the count is unchanged.
  - Push while full (no same-cycle pop): ID dropped, overflow_o set next cycle.
  - overflow_clr_i clears overflow_o; if a clear coincides with a new overflow, set wins.
- pending_o = current queue count.
- FSM states:
  - IDLE: if queue non-empty, pop the ID into cur_buf, word=0 -> FETCH.
  - FETCH: ram_rd_o=1, ram_addr_o={cur_buf,word} -> CAPTURE.
  - CAPTURE: hdr_dat_o<=ram_dat_i, hdr_valid_o<=1, hdr_last_o<=(word==HEADER_WORDS-1) -> PRESENT.
  - PRESENT: hold valid, data and last until hdr_ready_i. On handshake, hdr_valid_o<=0; if last -> RELEASE, else word+1 -> FETCH.
  - RELEASE: buffer_release_o[cur_buf]=1 for exactly one cycle -> IDLE.
- Throughput: 3 cycles per word with hdr_ready_i held high. First ram_rd_o comes 1 cycle after event_done_i when the block is idle and the queue empty.
- hdr_dat_o is stable while hdr_valid_o && !hdr_ready_i. hdr_buffer_o = cur_buf, constant across a header.
- ram_rd_o is high only in FETCH. ram_addr_o holds its last value otherwise.
- The word counter is 6 bits and does not wrap within a header (HEADER_WORDS <= 64).
- The block does not check for duplicate buffer IDs in the queue; it reads each one in order.

Optional Feature:
HEADER_CHECKSUM_EN:
- Defined: after word HEADER_WORDS-1 is accepted, emit one extra word equal to the 16-bit sum (mod 2^16) of all HEADER_WORDS data words. This word uses no RAM read: one cycle from the last handshake to valid. hdr_last_o moves to the checksum word; release follows its acceptance.
- Undefined: no extra word; hdr_last_o marks word HEADER_WORDS-1.

Test Plan:
- RAM buf 2 word n = 0x2000+n; pulse done with buffer=2, ready=1 -> 22 words 0x2000..0x2015 at addresses 0x80..0x95; last on 0x2015; buffer_release_o=4'b0100 one cycle after the final handshake; total 66 cycles plus the release cycle.
- Ready low for 5 cycles at word 7 -> hdr_dat_o held at the word-7 value with valid high; no extra ram_rd_o; stream resumes unchanged.
- Four done pulses (bufs 0,1,2,3) while streaming buf 0 -> pending_o reaches 3 and buf 0 is not lost. Headers emitted in order 0,1,2,3 and releases 0001,0010,0100,1000. A fifth push while full sets overflow_o and the ID is not read; overflow_clr_i clears it.
- done and pop in the same cycle with count=4 -> no overflow, pending_o stays 4.
- rst_n_i low at word 10 -> all outputs 0 immediately (asynchronous); no release; the next done streams a fresh header from word 0.
- HEADER_CHECKSUM_EN, buf 1 words all 0x0001 -> 23rd word 0x0016 with last set; without the macro, last on word 22 (index 21).
